// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, retire-order counter and IF/ID register.
// Single outstanding imem request; freezes on stall, squashes in-flight fetch on EX redirect.

typedef struct packed {
  logic [31:0] pc_s;
  logic [31:0] pc_next_s;
  logic        valid_s;
  logic [63:0] order_s;
} if_id_stage_reg_t;

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      imem_addr,
  output logic [3:0]       imem_rmask,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_resp,
  output if_id_stage_reg_t if_id,
  output logic [31:0]      if_id_inst
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [63:0]      order_q, order_d;
  logic             squash_q, squash_d;
  logic [31:0]      buf_q, buf_d;
  if_id_stage_reg_t if_id_d;
  logic [31:0]      inst_d;

  logic [31:0] pc_inc;
  logic        take_redirect;
  logic        accept;

  assign pc_inc        = pc_q + 32'd4;
  assign take_redirect = redirect & ~stall;
  assign accept        = imem_resp & ~squash_q & ~stall & ~redirect;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    order_d    = order_q;
    squash_d   = squash_q;
    buf_d      = buf_q;
    if_id_d    = if_id;
    inst_d     = if_id_inst;
    imem_addr  = (state_q == WAIT && accept) ? pc_inc : pc_q;
    imem_rmask = ((state_q == FETCH || (state_q == WAIT && accept)) && !rst) ? 4'hF : 4'h0;

    case (state_q)
      FETCH: begin
        state_d = WAIT;
        // The request above is already on the bus, so a redirect must squash its reply.
        if (take_redirect) begin
          squash_d        = 1'b1;
          pc_d            = redirect_pc;
          if_id_d.valid_s = 1'b0;
        end else if (!stall) begin
          if_id_d.valid_s = 1'b0;
        end
      end

      WAIT: begin
        if (imem_resp) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = FETCH;
            if (take_redirect) pc_d = redirect_pc;
            if (!stall) if_id_d.valid_s = 1'b0;
          end else if (take_redirect) begin
            pc_d            = redirect_pc;
            if_id_d.valid_s = 1'b0;
            state_d         = FETCH;
          end else if (stall) begin
            buf_d   = imem_rdata;
            state_d = HOLD;
          end else begin
            if_id_d.pc_s      = pc_q;
            if_id_d.pc_next_s = pc_inc;
            if_id_d.valid_s   = 1'b1;
            if_id_d.order_s   = order_q;
            inst_d            = imem_rdata;
            order_d           = order_q + 64'd1;
            pc_d              = pc_inc;
          end
        end else if (take_redirect) begin
          squash_d        = 1'b1;
          pc_d            = redirect_pc;
          if_id_d.valid_s = 1'b0;
        end else if (!stall) begin
          if_id_d.valid_s = 1'b0;
        end
      end

      HOLD: begin
        if (!stall) begin
          state_d = FETCH;
          if (redirect) begin
            pc_d            = redirect_pc;
            if_id_d.valid_s = 1'b0;
          end else begin
            if_id_d.pc_s      = pc_q;
            if_id_d.pc_next_s = pc_inc;
            if_id_d.valid_s   = 1'b1;
            if_id_d.order_s   = order_q;
            inst_d            = buf_q;
            order_d           = order_q + 64'd1;
            pc_d              = pc_inc;
          end
        end
      end

      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      order_q    <= 64'd0;
      squash_q   <= 1'b0;
      buf_q      <= 32'd0;
      if_id      <= '0;
      if_id_inst <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      order_q    <= order_d;
      squash_q   <= squash_d;
      buf_q      <= buf_d;
      if_id      <= if_id_d;
      if_id_inst <= inst_d;
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RV32I 5-stage pipeline. It owns the PC, the retire-order counter and the IF/ID stage register (`if_id_stage_reg_t` plus the fetched word). It issues single-outstanding requests on the instruction-memory port. It freezes on pipeline stall and squashes in-flight fetches on an EX-stage redirect (taken branch, jal, jalr). Next-PC prediction is static fall-through (pc+4).

## Interface
- `RESET_PC`, default 32'h1eceb000, first fetch address after reset.
- `clk` in 1: single clock, all state rising-edge.
- `rst` in 1: reset, asynchronous, active-high.
- `stall` in 1: global pipeline freeze from the stall controller (dmem wait); IF/ID register holds while high.
- `redirect` in 1: EX resolved a control transfer to a non-fall-through target; sampled only when `stall`=0.
- `redirect_pc` in 32: redirect target.
- `imem_addr` out 32: fetch address, valid when `imem_rmask`≠0.
- `imem_rmask` out 4: 4'hF for one cycle per request, else 4'h0.
- `imem_rdata` in 32: instruction word, valid with `imem_resp`.
- `imem_resp` in 1: one-cycle response pulse, ≥1 cycle after request.
- `if_id` out `if_id_stage_reg_t`: {pc_s, pc_next_s, valid_s, order_s}, registered.
- `if_id_inst` out 32: instruction paired with `if_id`, registered.

## Operation
- State: `pc_q`, `order_q` (64b), `squash_q`, FSM {FETCH, WAIT, HOLD}, 32b hold buffer.
- accept = `imem_resp` & !`squash_q` & !`stall` & !`redirect`.
- `imem_addr` = (WAIT & accept) ? `pc_q`+4 : `pc_q`.
- `imem_rmask` = 4'hF when (FETCH | (WAIT & accept)) & !`rst`; otherwise 0.
- **FETCH** behaviour:
  - Issue a request and go to WAIT.
  - If `redirect` & !`stall`: set `squash_q`, load `pc_q`←`redirect_pc`, clear `if_id.valid_s`.
  - Else if !`stall`: clear `if_id.valid_s`.
- **WAIT** behaviour, by priority:
  - resp & `squash_q`: clear squash and go to FETCH. A concurrent redirect (stall=0) also loads `pc_q`.
  - resp & `redirect` & !`stall`: drop the word, load `pc_q`←`redirect_pc`, clear valid, go to FETCH.
  - resp & `stall`: buffer `imem_rdata`, go to HOLD.
  - resp & accept: write `if_id`←{`pc_q`, `pc_q`+4, 1, `order_q`} and `if_id_inst`←`imem_rdata`. Then `order_q`++, `pc_q`+=4, issue the next request the same cycle, stay in WAIT.
  - no resp & `redirect` & !`stall`: set `squash_q`, load `pc_q`←`redirect_pc`, clear valid.
  - no resp & !`stall`: clear valid (bubble). With `stall`: hold everything.
- **HOLD** behaviour:
  - `stall`: hold; no request issued.
  - !`stall` & `redirect`: drop the buffer, load `pc_q`←`redirect_pc`, clear valid, go to FETCH.
  - !`stall`: write `if_id` from the buffer with `order_q`, then `order_q`++, `pc_q`+=4, go to FETCH.
- `order_q` increments only when a valid entry is written to IF/ID. Squashed or dropped fetches never consume an order.
- `pc_q`+4 wraps modulo 2^32. `redirect_pc` is used unaligned-as-given; alignment checking belongs to EX.
- At most one request is outstanding. `imem_resp` arriving in FETCH or HOLD is illegal and is not handled.

## Timing
- Reset (async) sets:
  - state FETCH, `pc_q`=`RESET_PC`, `order_q`=0, `squash_q`=0.
  - `if_id`=0 (`valid_s`=0), `if_id_inst`=0, buffer 0.
  - `imem_rmask`=0.
- First request occurs in the first cycle after `rst` deasserts.
- Fetch latency: request in cycle N, resp in N+k, `if_id` valid in N+k+1.
- Throughput with k=1 and no stall: one instruction per cycle.
- Redirect penalty: target request is issued the cycle after the redirect. If a request was outstanding, the target request waits for the squashed response, then issues one cycle later.
- Reset mid-WAIT drops the outstanding transaction. The bench must not return its response after reset.

## Test plan
- **Reset:** hold `rst`=1 → `imem_rmask`=0, `if_id.valid_s`=0, `order_s`=0. After release: `imem_addr`=32'h1eceb000, `imem_rmask`=4'hF.
- **Zero-wait stream:** resp every next cycle with rdata 32'h00000013 → consecutive valid `if_id`:
  - pc 1eceb000/004/008, pc_next pc+4, order 0/1/2.
  - `imem_rmask`=F every cycle.
- **Stall on response:** `stall`=1 in the resp cycle for 3 cycles → `if_id` frozen, `imem_rmask`=0. On release, the buffered word appears with the next order, then FETCH at pc+4.
- **Redirect while WAIT:** `redirect`=1, `redirect_pc`=32'h1eceb100 before resp → the response 2 cycles later is discarded. The next request is addr 1eceb100; `order_s` is unchanged and valid stays 0.
- **Redirect coincident with resp / HOLD release:** the word is dropped. The next cycle requests `redirect_pc`, with no order increment.
- **Async reset mid-WAIT:** assert `rst` between cycles → all outputs hit reset values immediately. The request at `RESET_PC` is issued after release.
